pr_free_list: RTL and testbench
===============================

Name: pr_free_list

Overview:
- Circular free-list manager for the physical register pool above the 32 permanently reserved architectural PRs.
- Hands out up to NUM_SICS PRs per cycle to the issue stage in slot order.
- Accepts up to NUM_SICS released PRs per cycle from commit.
- Keeps one head-pointer checkpoint per ECR so that a branch rollback reclaims every wrong-path allocation in one cycle.

Parameters:
- NUM_SICS, 2, allocation ports and free ports.
- NUM_PHY_REGS, 64, total PRs. FL_DEPTH = NUM_PHY_REGS-32 must be a power of two ≥ NUM_SICS; elaboration fails otherwise.
- NUM_ECRS, 2, number of checkpoint slots.
- Localparams: PR_W = $clog2(NUM_PHY_REGS), P_W = $clog2(FL_DEPTH)+1 (pointers carry a wrap bit), E_W = max(1,$clog2(NUM_ECRS)), S_W = max(1,$clog2(NUM_SICS)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req  in  [NUM_SICS]  slot k wants a PR.
- alloc_grant  out  [NUM_SICS]  slot k granted (combinational).
- alloc_pr  out  [NUM_SICS][PR_W]  PR for granted slot k; 0 when not granted.
- free_valid  in  [NUM_SICS]  release free_pr[k].
- free_pr  in  [NUM_SICS][PR_W]  PR being released.
- ckpt_save_valid  in  1  record a checkpoint this cycle.
- ckpt_save_id  in  E_W  ECR receiving the checkpoint.
- ckpt_save_slot  in  S_W  slot index of the branch; only grants in slots < this index precede the checkpoint.
- rollback_valid  in  1  restore a checkpoint.
- rollback_id  in  E_W  ECR whose checkpoint is restored.
- free_count  out  P_W  registered number of free entries.
- empty  out  1  free_count == 0.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- State:
  - fl[FL_DEPTH] array of PR_W entries.
  - head and tail pointers, each P_W bits.
  - ckpt_head[NUM_ECRS], each P_W bits.
  - free_count = tail - head (modulo 2^P_W).
- Reset (async, while rst=1):
  - fl[i] = 32+i; head = 0; tail = FL_DEPTH (wrap bit set, list full).
  - ckpt_head[*] = 0; err = 0.
  - alloc_grant = 0 and alloc_pr = 0 while rst is asserted.
- Grant, combinational, in-order prefix:
  - Slot k is granted iff alloc_req[k]=1, every lower slot with a request was granted, fewer than free_count grants have been made in slots < k, and rollback_valid=0.
  - A non-requesting slot does not block higher slots.
  - Once a requesting slot is denied, all higher slots are denied.
  - Index of the nth grant (n counted from 0) = fl[(head+n) mod FL_DEPTH].
- Alloc commit (clock edge): head += number of grants.
- Free (clock edge):
  - Each free_valid[k] writes fl[tail+j] = free_pr[k], where j is the rank of k among the valid frees; then tail += number of frees.
  - A freed PR is grantable from the next cycle onward. Same-cycle allocs see only the pre-free free_count.
- Checkpoint:
  - ckpt_head[ckpt_save_id] <= head + (grants in slots < ckpt_save_slot).
  - If rollback_valid=1 in the same cycle, the save is ignored.
- Rollback:
  - head <= ckpt_head[rollback_id]; all grants are forced to 0 that cycle.
  - Frees in the same cycle are still applied.
  - Entries between the restored head and the old head are reused unchanged.
- Upstream contract: wrong-path PRs are never freed before their rollback, and at most FL_DEPTH PRs are outstanding. Under this contract tail never overruns head.
- free_count, empty and err are registered and update on the edge after the event.

Optional Feature:
- Macro: PR_FREE_LIST_CHECK_EN.
- With the macro:
  - A FL_DEPTH-bit is_free bitmap is kept: cleared on grant, set on free, reset to all-ones.
  - A free of a PR < 32, of an already-free PR, or two equal free_pr in one cycle sets err (sticky until reset).
  - The offending free is dropped: no write and tail not advanced for it.
- Without the macro: err is tied to 0 and all frees are trusted.

Test Plan:
- Reset, then alloc_req=2'b11 → grants 11, alloc_pr={32,33}; next cycle free_count=FL_DEPTH-2=30.
- Drain to free_count=1, then alloc_req=11 → only slot0 granted; empty=1 next cycle; next alloc_req=01 → grant 0.
- Drain to empty, then free 40 and 41 with alloc_req=01 in the same cycle → no grant; next cycle grant slot0 with alloc_pr=40.
- ckpt_save id0 slot1 with alloc_req=11 → ckpt=head+1; two more grant cycles; rollback id0 → free_count back to FL_DEPTH-1; next grant returns 33.
- rollback_valid=1 with alloc_req=11 and free_valid=01 → grants 00; the free is written and the count reflects it.
- With PR_FREE_LIST_CHECK_EN defined: free PR 5, then double-free 34 → err=1 and tail unchanged; without the macro, err stays 0.

Source files
------------

// File: rtl/pr_free_list_if.sv
// Allocation, release, checkpoint and rollback signals of the physical-register free list.
// master drives requests (issue/commit/branch logic); slave is the free list itself.
interface pr_free_list_if #(
  parameter int NUM_SICS     = 2,
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_ECRS     = 2
);
  localparam int FL_DEPTH = NUM_PHY_REGS - 32;
  localparam int PR_W     = $clog2(NUM_PHY_REGS);
  localparam int P_W      = $clog2(FL_DEPTH) + 1;
  localparam int E_W      = (NUM_ECRS > 1) ? $clog2(NUM_ECRS) : 1;
  localparam int S_W      = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  logic [NUM_SICS-1:0]           alloc_req;
  logic [NUM_SICS-1:0]           alloc_grant;
  logic [NUM_SICS-1:0][PR_W-1:0] alloc_pr;
  logic [NUM_SICS-1:0]           free_valid;
  logic [NUM_SICS-1:0][PR_W-1:0] free_pr;
  logic                          ckpt_save_valid;
  logic [E_W-1:0]                ckpt_save_id;
  logic [S_W-1:0]                ckpt_save_slot;
  logic                          rollback_valid;
  logic [E_W-1:0]                rollback_id;
  logic [P_W-1:0]                free_count;
  logic                          empty;
  logic                          err;

  modport master (
    output alloc_req,
    output free_valid,
    output free_pr,
    output ckpt_save_valid,
    output ckpt_save_id,
    output ckpt_save_slot,
    output rollback_valid,
    output rollback_id,
    input  alloc_grant,
    input  alloc_pr,
    input  free_count,
    input  empty,
    input  err
  );

  modport slave (
    input  alloc_req,
    input  free_valid,
    input  free_pr,
    input  ckpt_save_valid,
    input  ckpt_save_id,
    input  ckpt_save_slot,
    input  rollback_valid,
    input  rollback_id,
    output alloc_grant,
    output alloc_pr,
    output free_count,
    output empty,
    output err
  );
endinterface

// File: rtl/pr_free_list.sv
// Circular free list for the PRs above the 32 reserved architectural registers, with one head
// checkpoint per ECR for single-cycle rollback. Define PR_FREE_LIST_CHECK_EN for free-side checks and err.
module pr_free_list #(
  parameter int NUM_SICS     = 2,
  parameter int NUM_PHY_REGS = 64,
  parameter int NUM_ECRS     = 2
) (
  input  logic           clk,
  input  logic           rst,
  pr_free_list_if.slave  fl_if
);
  localparam int FL_DEPTH = NUM_PHY_REGS - 32;
  localparam int PR_W     = $clog2(NUM_PHY_REGS);
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int P_W      = IDX_W + 1;
  localparam int C_W      = $clog2(NUM_SICS + 1);

  generate
    if ((FL_DEPTH < 1) || ((FL_DEPTH & (FL_DEPTH - 1)) != 0) || (FL_DEPTH < NUM_SICS)) begin : g_bad_cfg
      $error("pr_free_list: NUM_PHY_REGS-32 must be a power of two and >= NUM_SICS");
    end
  endgenerate

  logic [PR_W-1:0]                fl [FL_DEPTH];
  logic [P_W-1:0]                 head;
  logic [P_W-1:0]                 tail;
  logic [P_W-1:0]                 head_nxt;
  logic [P_W-1:0]                 tail_nxt;
  logic [P_W-1:0]                 ckpt_head [NUM_ECRS];
  logic [P_W-1:0]                 free_count_q;
  logic                           empty_q;

  logic [NUM_SICS-1:0]            grant;
  logic [NUM_SICS-1:0][PR_W-1:0]  grant_pr;
  logic [C_W-1:0]                 grant_cnt;
  logic [C_W-1:0]                 pre_save_cnt;
  logic                           blocked;

  logic [NUM_SICS-1:0]            free_ok;
  logic [NUM_SICS-1:0]            wr_en;
  logic [NUM_SICS-1:0][IDX_W-1:0] wr_idx;
  logic [C_W-1:0]                 free_cnt;

  // In-order prefix grant: the first denied requester blocks every higher slot,
  // idle slots do not. Only the registered (pre-free) count is offered.
  always_comb begin
    grant        = '0;
    grant_pr     = '0;
    grant_cnt    = '0;
    pre_save_cnt = '0;
    blocked      = 1'b0;
    for (int k = 0; k < NUM_SICS; k++) begin
      if (int'(fl_if.ckpt_save_slot) == k) pre_save_cnt = grant_cnt;
      if (fl_if.alloc_req[k]) begin
        if (!blocked && !fl_if.rollback_valid && !rst &&
            (P_W'(grant_cnt) < free_count_q)) begin
          grant[k]    = 1'b1;
          grant_pr[k] = fl[IDX_W'(head + P_W'(grant_cnt))];
          grant_cnt   = grant_cnt + C_W'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end
    if (int'(fl_if.ckpt_save_slot) >= NUM_SICS) pre_save_cnt = grant_cnt;
  end

`ifdef PR_FREE_LIST_CHECK_EN
  logic [FL_DEPTH-1:0] is_free;
  logic [NUM_SICS-1:0] free_bad;
  logic                err_q;

  // A release is bad if it names a reserved PR, a PR already on the list,
  // or repeats a PR named by a lower slot in the same cycle.
  always_comb begin
    free_bad = '0;
    for (int k = 0; k < NUM_SICS; k++) begin
      if (fl_if.free_valid[k]) begin
        if ((fl_if.free_pr[k] < PR_W'(32)) ||
            is_free[IDX_W'(fl_if.free_pr[k] - PR_W'(32))]) begin
          free_bad[k] = 1'b1;
        end
        for (int j = 0; j < k; j++) begin
          if (fl_if.free_valid[j] && (fl_if.free_pr[j] == fl_if.free_pr[k])) free_bad[k] = 1'b1;
        end
      end
    end
  end

  assign free_ok = fl_if.free_valid & ~free_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_free <= '1;
      err_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_SICS; k++) begin
        if (grant[k]) is_free[IDX_W'(grant_pr[k] - PR_W'(32))] <= 1'b0;
      end
      for (int k = 0; k < NUM_SICS; k++) begin
        if (free_ok[k]) is_free[IDX_W'(fl_if.free_pr[k] - PR_W'(32))] <= 1'b1;
      end
      if (|free_bad) err_q <= 1'b1;
    end
  end

  assign fl_if.err = err_q;
`else
  assign free_ok   = fl_if.free_valid;
  assign fl_if.err = 1'b0;
`endif

  // Accepted releases are packed at the tail in slot order.
  always_comb begin
    wr_en    = '0;
    wr_idx   = '0;
    free_cnt = '0;
    for (int k = 0; k < NUM_SICS; k++) begin
      if (free_ok[k]) begin
        wr_en[k]  = 1'b1;
        wr_idx[k] = IDX_W'(tail + P_W'(free_cnt));
        free_cnt  = free_cnt + C_W'(1);
      end
    end
  end

  assign head_nxt = fl_if.rollback_valid ? ckpt_head[fl_if.rollback_id]
                                         : head + P_W'(grant_cnt);
  assign tail_nxt = tail + P_W'(free_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= P_W'(FL_DEPTH);
      free_count_q <= P_W'(FL_DEPTH);
      empty_q      <= 1'b0;
      for (int e = 0; e < NUM_ECRS; e++) ckpt_head[e] <= '0;
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PR_W'(32 + i);
    end else begin
      head         <= head_nxt;
      tail         <= tail_nxt;
      free_count_q <= tail_nxt - head_nxt;
      empty_q      <= (tail_nxt == head_nxt);
      // Rollback wins over a same-cycle save; the saved head excludes grants at or above the branch slot.
      if (fl_if.ckpt_save_valid && !fl_if.rollback_valid) begin
        ckpt_head[fl_if.ckpt_save_id] <= head + P_W'(pre_save_cnt);
      end
      for (int k = 0; k < NUM_SICS; k++) begin
        if (wr_en[k]) fl[wr_idx[k]] <= fl_if.free_pr[k];
      end
    end
  end

  assign fl_if.alloc_grant = grant;
  assign fl_if.alloc_pr    = grant_pr;
  assign fl_if.free_count  = free_count_q;
  assign fl_if.empty       = empty_q;

endmodule

// File: tb/tb_pr_free_list.sv
// Directed bench for pr_free_list: queue-based reference model checked every cycle,
// plus hand-computed expectations along the directed sequence.
`timescale 1ns/1ps
module tb_pr_free_list;
  localparam int NUM_SICS     = 2;
  localparam int NUM_PHY_REGS = 64;
  localparam int NUM_ECRS     = 2;
  localparam int FL_DEPTH     = NUM_PHY_REGS - 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pr_free_list_if #(.NUM_SICS(NUM_SICS), .NUM_PHY_REGS(NUM_PHY_REGS), .NUM_ECRS(NUM_ECRS)) fl_if ();

  pr_free_list #(.NUM_SICS(NUM_SICS), .NUM_PHY_REGS(NUM_PHY_REGS), .NUM_ECRS(NUM_ECRS)) dut (
    .clk   (clk),
    .rst   (rst),
    .fl_if (fl_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of free PRs, log of PRs handed out, checkpoints as log positions.
  int mq[$];
  int alog[$];
  int ckpt_pos [NUM_ECRS];
  bit m_is_free [NUM_PHY_REGS];
  bit m_err;
  int m_n, m_pre, m_pr, m_id;
  bit m_blocked, m_ok;
  bit m_eg [NUM_SICS];
  int m_epr [NUM_SICS];

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      alog.delete();
      for (int i = 0; i < FL_DEPTH; i++) mq.push_back(32 + i);
      for (int e = 0; e < NUM_ECRS; e++) ckpt_pos[e] = 0;
      for (int p = 0; p < NUM_PHY_REGS; p++) m_is_free[p] = (p >= 32);
      m_err = 1'b0;
      chk("rst alloc_grant", 64'(fl_if.alloc_grant), 0);
      chk("rst alloc_pr", 64'(fl_if.alloc_pr), 0);
      chk("rst free_count", 64'(fl_if.free_count), FL_DEPTH);
    end else begin
      chk("model free_count", 64'(fl_if.free_count), 64'(mq.size()));
      chk("model empty", 64'(fl_if.empty), 64'(mq.size() == 0));
      chk("model err", 64'(fl_if.err), 64'(m_err));
      m_n = 0; m_pre = 0; m_blocked = 1'b0;
      for (int k = 0; k < NUM_SICS; k++) begin
        m_eg[k] = 1'b0; m_epr[k] = 0;
        if (fl_if.alloc_req[k]) begin
          if (!m_blocked && !fl_if.rollback_valid && (m_n < mq.size())) begin
            m_eg[k] = 1'b1;
            m_epr[k] = mq[m_n];
            m_n++;
            if (k < int'(fl_if.ckpt_save_slot)) m_pre++;
          end else begin
            m_blocked = 1'b1;
          end
        end
        chk($sformatf("model alloc_grant[%0d]", k), 64'(fl_if.alloc_grant[k]), 64'(m_eg[k]));
        chk($sformatf("model alloc_pr[%0d]", k), 64'(fl_if.alloc_pr[k]), 64'(m_epr[k]));
      end
      if (fl_if.ckpt_save_valid && !fl_if.rollback_valid)
        ckpt_pos[fl_if.ckpt_save_id] = alog.size() + m_pre;
      for (int g = 0; g < m_n; g++) begin
        m_pr = mq.pop_front();
        alog.push_back(m_pr);
        m_is_free[m_pr] = 1'b0;
      end
      if (fl_if.rollback_valid) begin
        m_id = int'(fl_if.rollback_id);
        while (alog.size() > ckpt_pos[m_id]) mq.push_front(alog.pop_back());
      end
      for (int k = 0; k < NUM_SICS; k++) begin
        if (fl_if.free_valid[k]) begin
          m_pr = int'(fl_if.free_pr[k]);
          m_ok = 1'b1;
`ifdef PR_FREE_LIST_CHECK_EN
          if (m_pr < 32 || m_is_free[m_pr]) m_ok = 1'b0;
          for (int j = 0; j < k; j++)
            if (fl_if.free_valid[j] && fl_if.free_pr[j] == fl_if.free_pr[k]) m_ok = 1'b0;
          if (!m_ok) m_err = 1'b1;
`endif
          if (m_ok) begin
            mq.push_back(m_pr);
            m_is_free[m_pr] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fl_if.alloc_req       = '0;
    fl_if.free_valid      = '0;
    fl_if.free_pr         = '0;
    fl_if.ckpt_save_valid = 1'b0;
    fl_if.ckpt_save_id    = '0;
    fl_if.ckpt_save_slot  = '0;
    fl_if.rollback_valid  = 1'b0;
    fl_if.rollback_id     = '0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    @(negedge clk);
    chk("reset free_count", 64'(fl_if.free_count), 32);
    chk("reset empty", 64'(fl_if.empty), 0);
    chk("reset grant", 64'(fl_if.alloc_grant), 0);
    tick();
    rst = 1'b0;

    // Two grants out of a full list.
    fl_if.alloc_req = 2'b11;
    @(negedge clk);
    chk("first grant", 64'(fl_if.alloc_grant), 3);
    chk("first pr0", 64'(fl_if.alloc_pr[0]), 32);
    chk("first pr1", 64'(fl_if.alloc_pr[1]), 33);
    tick();
    fl_if.alloc_req = '0;
    @(negedge clk);
    chk("count after first", 64'(fl_if.free_count), 30);

    // Drain to one entry, then a two-wide request gets only slot 0.
    tick();
    fl_if.alloc_req = 2'b11;
    repeat (14) tick();
    fl_if.alloc_req = 2'b01;
    tick();
    fl_if.alloc_req = 2'b11;
    @(negedge clk);
    chk("count one left", 64'(fl_if.free_count), 1);
    chk("partial grant", 64'(fl_if.alloc_grant), 1);
    chk("partial pr0", 64'(fl_if.alloc_pr[0]), 63);
    chk("partial pr1", 64'(fl_if.alloc_pr[1]), 0);
    tick();
    fl_if.alloc_req = 2'b01;
    @(negedge clk);
    chk("empty set", 64'(fl_if.empty), 1);
    chk("grant on empty", 64'(fl_if.alloc_grant), 0);

    // Frees become grantable only on the following cycle.
    tick();
    fl_if.free_valid = 2'b11;
    fl_if.free_pr[0] = 6'd40;
    fl_if.free_pr[1] = 6'd41;
    @(negedge clk);
    chk("no grant same-cycle free", 64'(fl_if.alloc_grant), 0);
    tick();
    fl_if.free_valid = '0;
    @(negedge clk);
    chk("count after frees", 64'(fl_if.free_count), 2);
    chk("grant freed", 64'(fl_if.alloc_grant), 1);
    chk("freed pr0", 64'(fl_if.alloc_pr[0]), 40);
    tick();
    fl_if.alloc_req = 2'b10;
    @(negedge clk);
    chk("idle slot0 grant", 64'(fl_if.alloc_grant), 2);
    chk("idle slot0 pr1", 64'(fl_if.alloc_pr[1]), 41);
    chk("idle slot0 pr0", 64'(fl_if.alloc_pr[0]), 0);
    tick();
    idle();

    // Checkpoint after slot 0, two more grant cycles, then roll back.
    reset_pulse();
    fl_if.alloc_req       = 2'b11;
    fl_if.ckpt_save_valid = 1'b1;
    fl_if.ckpt_save_id    = 1'b0;
    fl_if.ckpt_save_slot  = 1'b1;
    @(negedge clk);
    chk("ckpt cycle grant", 64'(fl_if.alloc_grant), 3);
    tick();
    fl_if.ckpt_save_valid = 1'b0;
    repeat (2) tick();
    fl_if.rollback_valid = 1'b1;
    fl_if.rollback_id    = 1'b0;
    @(negedge clk);
    chk("rollback blocks grant", 64'(fl_if.alloc_grant), 0);
    chk("count before rollback", 64'(fl_if.free_count), 26);
    tick();
    fl_if.rollback_valid = 1'b0;
    fl_if.alloc_req      = 2'b01;
    @(negedge clk);
    chk("count after rollback", 64'(fl_if.free_count), 31);
    chk("regrant pr0", 64'(fl_if.alloc_pr[0]), 33);
    tick();

    // Rollback with a same-cycle free and a same-cycle save that must be ignored.
    fl_if.alloc_req       = 2'b11;
    fl_if.ckpt_save_valid = 1'b1;
    fl_if.ckpt_save_id    = 1'b1;
    fl_if.ckpt_save_slot  = 1'b0;
    @(negedge clk);
    chk("ckpt1 pr0", 64'(fl_if.alloc_pr[0]), 34);
    chk("ckpt1 pr1", 64'(fl_if.alloc_pr[1]), 35);
    tick();
    fl_if.rollback_valid = 1'b1;
    fl_if.rollback_id    = 1'b1;
    fl_if.free_valid     = 2'b01;
    fl_if.free_pr[0]     = 6'd33;
    @(negedge clk);
    chk("rb+free grant", 64'(fl_if.alloc_grant), 0);
    chk("rb+free count before", 64'(fl_if.free_count), 28);
    tick();
    idle();
    @(negedge clk);
    chk("rb+free count after", 64'(fl_if.free_count), 31);
    tick();
    fl_if.rollback_valid = 1'b1;
    fl_if.rollback_id    = 1'b1;
    tick();
    idle();
    fl_if.alloc_req = 2'b01;
    @(negedge clk);
    chk("ignored save count", 64'(fl_if.free_count), 31);
    chk("ignored save pr0", 64'(fl_if.alloc_pr[0]), 34);
    tick();
    idle();

`ifdef PR_FREE_LIST_CHECK_EN
    reset_pulse();
    fl_if.free_valid = 2'b01;
    fl_if.free_pr[0] = 6'd5;
    tick();
    idle();
    @(negedge clk);
    chk("err reserved PR", 64'(fl_if.err), 1);
    chk("count reserved PR", 64'(fl_if.free_count), 32);
    tick();
    reset_pulse();
    @(negedge clk);
    chk("err cleared by reset", 64'(fl_if.err), 0);
    tick();
    fl_if.free_valid = 2'b01;
    fl_if.free_pr[0] = 6'd34;
    tick();
    idle();
    @(negedge clk);
    chk("err double free", 64'(fl_if.err), 1);
    chk("count double free", 64'(fl_if.free_count), 32);
    tick();
    reset_pulse();
    fl_if.alloc_req = 2'b11;
    tick();
    idle();
    fl_if.free_valid = 2'b11;
    fl_if.free_pr[0] = 6'd32;
    fl_if.free_pr[1] = 6'd32;
    tick();
    idle();
    @(negedge clk);
    chk("err dup free", 64'(fl_if.err), 1);
    chk("count dup free", 64'(fl_if.free_count), 31);
    tick();
`else
    @(negedge clk);
    chk("err tied low", 64'(fl_if.err), 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
